// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock divider.
// Ratio limits and FSM state encoding live here.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int CNT_W_DEF   = 8;
  localparam int DIV_RST_DEF = 8;
  localparam int DIV_MIN     = 2;

endpackage

// File: rtl/clk_div_if.sv
// Control/status bundle of the programmable clock divider.
// master drives run/load requests, slave returns clock and pulses.
interface clk_div_if #(
  parameter int CNT_W = clk_div_pkg::CNT_W_DEF
);

  logic             en;
  logic             div_load;
  logic [CNT_W-1:0] div_val;
  logic             clk_div;
  logic             tick;
  logic             load_ack;
  logic             load_err;

  modport master (
    output en, div_load, div_val,
    input  clk_div, tick, load_ack, load_err
  );

  modport slave (
    input  en, div_load, div_val,
    output clk_div, tick, load_ack, load_err
  );

endinterface

// File: rtl/clk_div_phase.sv
// Negedge phase flop and even/odd output combine.
// Keeps the only dual-edge logic of the divider in one place.
module clk_div_phase (
  input  logic clk,
  input  logic rstn,
  input  logic q_p,
  input  logic odd,
  output logic clk_div
);

  logic q_n;

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) q_n <= 1'b0;
    else       q_n <= q_p;
  end

  // odd only changes at a period boundary, where q_p and q_n are both low
  assign clk_div = odd ? (q_p & q_n) : q_p;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: run FSM, period counter, ratio load and tick.
// The cycle after leaving IDLE acts as the last slot of an empty period.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_div,
  output logic             tick,
  output logic             load_ack,
  output logic             load_err
);

  localparam logic [CNT_W-1:0] RST_V = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] act, act_nx;
  logic [CNT_W-1:0] pend, pend_nx;
  logic [CNT_W-1:0] half;
  logic             pend_v, pend_v_nx;
  logic             q_p, q_p_nx;
  logic             odd;
  logic             tick_nx, ack_nx, err_nx;
  logic             load_ok, wrap;

  assign load_ok = div_load && (div_val >= MIN_V);
  assign wrap    = (state == RUN) && (cnt == act - ONE);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    act_nx    = act;
    pend_nx   = pend;
    pend_v_nx = pend_v;
    ack_nx    = 1'b0;
    err_nx    = div_load && !load_ok;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (load_ok) begin
          act_nx    = div_val;
          ack_nx    = 1'b1;
          pend_v_nx = 1'b0;
        end else if (pend_v) begin
          act_nx    = pend;
          ack_nx    = 1'b1;
          pend_v_nx = 1'b0;
        end
        if (en) begin
          state_nx = RUN;
          cnt_nx   = act_nx - ONE;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_nx = '0;
          if (pend_v) begin
            act_nx    = pend;
            ack_nx    = 1'b1;
            pend_v_nx = 1'b0;
          end
          if (!en) state_nx = IDLE;
        end else begin
          cnt_nx = cnt + ONE;
        end
        // a load on the wrap edge stays pending for the following wrap
        if (load_ok) begin
          pend_nx   = div_val;
          pend_v_nx = 1'b1;
        end
      end
    endcase
  end

  assign half    = (act_nx >> 1) + {{(CNT_W-1){1'b0}}, act_nx[0]};
  assign q_p_nx  = (state_nx == RUN) && (cnt_nx < half);
  assign tick_nx = (state_nx == RUN) && (cnt_nx == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      act      <= RST_V;
      pend     <= '0;
      pend_v   <= 1'b0;
      q_p      <= 1'b0;
      odd      <= RST_V[0];
      tick     <= 1'b0;
      load_ack <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      act      <= act_nx;
      pend     <= pend_nx;
      pend_v   <= pend_v_nx;
      q_p      <= q_p_nx;
      odd      <= act_nx[0];
      tick     <= tick_nx;
      load_ack <= ack_nx;
      load_err <= err_nx;
    end
  end

  clk_div_phase u_phase (
    .clk     (clk),
    .rstn    (rstn),
    .q_p     (q_p),
    .odd     (odd),
    .clk_div (clk_div)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: vector table, corner sequences
// and random traffic against a period/half-cycle reference model.
module tb_clk_div_prog;
  import clk_div_pkg::*;

  localparam int W = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  clk_div_if #(.CNT_W(W)) bus ();

  clk_div_prog #(.CNT_W(W), .DIV_RST(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (bus.en),
    .div_load (bus.div_load),
    .div_val  (bus.div_val),
    .clk_div  (bus.clk_div),
    .tick     (bus.tick),
    .load_ack (bus.load_ack),
    .load_err (bus.load_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string name, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // model: period position -1 is the arming cycle after leaving idle
  bit m_run;
  int m_pos, m_n, m_pend;
  bit m_tick, m_ack, m_err;

  function automatic void m_reset();
    m_run = 0; m_pos = 0; m_n = 8; m_pend = 0;
    m_tick = 0; m_ack = 0; m_err = 0;
  endfunction

  function automatic void m_edge(bit e, bit ld, int v);
    bit ok;
    ok = ld && (v >= 2);
    m_err = ld && !ok;
    m_ack = 0;
    if (!m_run) begin
      if (m_pend != 0) begin m_n = m_pend; m_pend = 0; m_ack = 1; end
      if (ok) begin m_n = v; m_ack = 1; end
      if (e) begin m_run = 1; m_pos = -1; end
    end else begin
      if (m_pos == -1 || m_pos == m_n - 1) begin
        if (m_pend != 0) begin m_n = m_pend; m_pend = 0; m_ack = 1; end
        if (e) m_pos = 0;
        else m_run = 0;
      end else begin
        m_pos++;
      end
      if (ok) m_pend = v;
    end
    m_tick = m_run && (m_pos == 0);
  endfunction

  // high for N half-periods; odd ratios start half a clk late
  function automatic int m_clk(int h);
    int t;
    if (!m_run || m_pos < 0) return 0;
    t = 2 * m_pos + h;
    if (m_n % 2 == 1) return int'(t >= 1 && t <= m_n);
    return int'(t < m_n);
  endfunction

  int s_clk0, s_clk1, ack_cnt, tick_cnt;

  task automatic step();
    @(posedge clk);
    m_edge(bus.en, bus.div_load, int'(bus.div_val));
    #1;
    s_clk0 = int'(bus.clk_div);
    if (bus.load_ack) ack_cnt++;
    if (bus.tick) tick_cnt++;
    chk("tick", int'(bus.tick), int'(m_tick));
    chk("load_ack", int'(bus.load_ack), int'(m_ack));
    chk("load_err", int'(bus.load_err), int'(m_err));
    chk("clk_div_pos", s_clk0, m_clk(0));
    @(negedge clk);
    #1;
    s_clk1 = int'(bus.clk_div);
    chk("clk_div_neg", s_clk1, m_clk(1));
  endtask

  task automatic drive(bit e, bit ld, int v);
    bus.en = e;
    bus.div_load = ld;
    bus.div_val = W'(v);
    step();
    bus.div_load = 1'b0;
  endtask

  task automatic measure(output int per, output int hi);
    int k;
    per = -1; hi = 0; k = 0;
    while (!bus.tick && k < 600) begin step(); k++; end
    if (!bus.tick) return;
    k = 0;
    do begin
      hi += s_clk0 + s_clk1;
      step();
      k++;
    end while (!bus.tick && k < 600);
    if (bus.tick) per = k;
  endtask

  typedef struct {
    bit en; bit ld; int val;
    bit clk_div; bit tick; bit err;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int per, hi;
    bus.en = 0; bus.div_load = 0; bus.div_val = '0;
    m_reset();
    s_clk0 = 0; s_clk1 = 0; ack_cnt = 0; tick_cnt = 0;

    #12;
    chk("rst_clk_div", int'(bus.clk_div), 0);
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_ack", int'(bus.load_ack), 0);
    chk("rst_err", int'(bus.load_err), 0);
    @(negedge clk);
    rstn = 1'b1;

    tbl[0]  = '{1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 1, 1, 0};
    tbl[2]  = '{1, 0, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 0, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 1, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 1, 1, 0};
    tbl[10] = '{1, 1, 1, 1, 0, 1};
    tbl[11] = '{1, 0, 0, 1, 0, 0};
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].en, tbl[i].ld, tbl[i].val);
      chk($sformatf("vec%0d_clk", i), int'(bus.clk_div), int'(tbl[i].clk_div));
      chk($sformatf("vec%0d_tick", i), int'(bus.tick), int'(tbl[i].tick));
      chk($sformatf("vec%0d_err", i), int'(bus.load_err), int'(tbl[i].err));
    end

    measure(per, hi);
    chk("n8_period", per, 8);
    chk("n8_high_halves", hi, 8);

    drive(1, 1, 5);
    measure(per, hi);
    chk("n5_period", per, 5);
    chk("n5_high_halves", hi, 5);

    ack_cnt = 0;
    drive(1, 1, 3);
    drive(1, 1, 6);
    for (int i = 0; i < 12; i++) step();
    chk("last_load_single_ack", ack_cnt, 1);
    measure(per, hi);
    chk("n6_period", per, 6);
    drive(1, 1, 1);
    chk("bad_load_err", int'(bus.load_err), 1);
    measure(per, hi);
    chk("n6_kept_period", per, 6);
    chk("n6_high_halves", hi, 6);

    drive(1, 1, 8);
    measure(per, hi);
    chk("n8_again", per, 8);
    step();
    step();
    tick_cnt = 0;
    hi = 0;
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      hi += s_clk0 + s_clk1;
    end
    chk("stop_no_tick", tick_cnt, 0);
    chk("stop_tail_high", hi, 2);
    chk("stop_idle", int'(dut.state), int'(IDLE));
    chk("stop_low", int'(bus.clk_div), 0);

    drive(1, 1, 7);
    measure(per, hi);
    chk("n7_period", per, 7);
    chk("n7_high_halves", hi, 7);
    step();
    chk("n7_high_mid", int'(bus.clk_div), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_clk_div", int'(bus.clk_div), 0);
    chk("arst_tick", int'(bus.tick), 0);
    chk("arst_ack", int'(bus.load_ack), 0);
    chk("arst_err", int'(bus.load_err), 0);
    m_reset();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    bus.en = 1'b1;
    measure(per, hi);
    chk("post_rst_period", per, 8);
    chk("post_rst_high", hi, 8);

    drive(1, 1, 255);
    measure(per, hi);
    chk("n255_period", per, 255);
    chk("n255_high_halves", hi, 255);

    for (int i = 0; i < 3000; i++) begin
      bit e, ld;
      int v;
      e  = ($urandom % 16) != 0;
      ld = ($urandom % 8) == 0;
      v  = $urandom_range(0, 20);
      drive(e, ld, v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the divide ratio and the period counter.
REQ-002 SHALL have parameter DIV_RST, default 8: divide ratio after reset; legal range 2..2^CNT_W-1.
REQ-003 SHALL have port clk  input  1: single clock for all logic; the odd-duty stage uses its negative edge.
REQ-004 SHALL have port rstn  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1: run request; level-sensitive.
REQ-006 SHALL have port div_load  input  1: one-cycle request to load div_val.
REQ-007 SHALL have port div_val  input  CNT_W: requested divide ratio N; sampled only when div_load=1.
REQ-008 SHALL have port clk_div  output  1: divided clock, 50% duty for both even and odd N.
REQ-009 SHALL have port tick  output  1: one-clk pulse at the start of each divided period.
REQ-010 SHALL have port load_ack  output  1: one-clk pulse when a pending ratio becomes active.
REQ-011 SHALL have port load_err  output  1: one-clk pulse when a load is rejected.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (counter held at 0, clk_div=0) and RUN.
REQ-013 IDLE->RUN SHALL occur on the posedge where en=1; clk_div SHALL rise on the next posedge, with tick=1 in that cycle.
REQ-014 In RUN, the period counter cnt SHALL count 0..N-1 and wrap to 0; N is the active ratio.
REQ-015 Posedge phase q_p SHALL be 1 for cnt in 0..ceil(N/2)-1 and 0 otherwise.
REQ-016 Even N: clk_div=q_p, i.e. high N/2 and low N/2 clk cycles.
REQ-017 Odd N: q_n is q_p registered on negedge clk, and clk_div=q_p AND q_n, giving high and low of N/2 clk periods each.
REQ-018 clk_div SHALL be glitch-free: the only combinational term is the registered-AND of REQ-017, and the even/odd select changes only while q_p=q_n=0.
REQ-019 en deasserted in RUN SHALL let the current period finish; RUN->IDLE occurs at the wrap, so clk_div ends low and no truncated pulse is produced.
REQ-020 en reasserted before that wrap SHALL cancel the stop; periods continue with no gap.
REQ-021 A div_load with div_val<2 SHALL pulse load_err on the next cycle and leave active and pending ratios unchanged.
REQ-022 A div_load with a valid value in RUN SHALL be stored as pending; a later load before apply overwrites it, and only the last value is applied.
REQ-023 Pending SHALL be applied at the next wrap (cnt N-1->0); load_ack SHALL pulse in the first cycle of the new period.
REQ-024 A valid div_load in IDLE SHALL apply on the next cycle with load_ack.
REQ-025 div_load in the same cycle as a wrap SHALL be applied at the following wrap, not the current one.
REQ-026 tick SHALL be registered, high exactly in the first clk cycle of each RUN period (cnt=0).
REQ-027 Counter arithmetic SHALL be unsigned CNT_W-bit; N=2^CNT_W-1 SHALL work without overflow.

Reset
REQ-028 rstn low SHALL immediately force: FSM=IDLE, cnt=0, q_p=0, q_n=0, clk_div=0, tick=0, load_ack=0, load_err=0, active ratio=DIV_RST, pending cleared.
REQ-029 Reset mid-period SHALL truncate clk_div asynchronously; this is the only permitted truncated pulse.
REQ-030 Both the posedge and negedge flops SHALL use the same asynchronous active-low rstn.

Structure
REQ-031 Package clk_div_pkg SHALL hold the FSM state typedef (IDLE, RUN), the CNT_W and DIV_RST defaults, and the minimum legal ratio constant (2).
REQ-032 Sub-module clk_div_phase SHALL contain the negedge q_n flop and the even/odd output combine, keeping dual-edge logic isolated.
REQ-033 Top-level SHALL contain the FSM, counter, ratio load logic and tick.

Verification
REQ-034 Reset, en=1, N=8 (default): clk_div rises 1 clk after en, then repeats 4 high / 4 low; tick every 8 clks.
REQ-035 Load div_val=5 in RUN: load_ack at the next wrap; then clk_div is 2.5 high / 2.5 low clk periods, checked on both clk edges.
REQ-036 Load 3 then 6 within one period: only 6 is applied, with one load_ack; load div_val=1 gives load_err and the ratio is unchanged.
REQ-037 en dropped at cnt=2 with N=8: the period completes (ends low at cnt wrap), FSM enters IDLE, and no further tick occurs.
REQ-038 rstn asserted mid-high phase with N=7: all outputs are 0 immediately; after release plus en, the ratio is 8.
REQ-039 N=255 with CNT_W=8: the period is exactly 255 clks, with 127.5 clks high.
